button_event: RTL

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event_pkg.sv | 14 +
 rtl/button_event.sv | 113 +++++++++++
 2 files changed

// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared FSM encoding and default timing constants for button_event
package button_event_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int          DEF_CNT_W  = 24;
   localparam int unsigned DEF_LONG_N = 32'h00FF_FFFF;
   localparam int unsigned DEF_RPT_N  = 32'h003F_FFFF;

endpackage

// File: rtl/button_event.sv
// rtl/button_event.sv - press/release/click/long-press/auto-repeat event generator
// The port "rel" carries the release pulse; "release" is a reserved word in SystemVerilog.
module button_event
   import button_event_pkg::*;
#(
   parameter int          CNT_W  = DEF_CNT_W,
   parameter int unsigned LONG_N = DEF_LONG_N,
   parameter int unsigned RPT_N  = DEF_RPT_N
) (
   input  logic clk,
   input  logic rst,
   input  logic I,
   output logic press,
   output logic rel,
   output logic click,
   output logic long_press,
   output logic rpt,
   output logic held
);

   localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_N);
   localparam logic [CNT_W-1:0] RPT_T  = CNT_W'(RPT_N);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_d, rel_d, click_d, long_d, rpt_d, held_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         press      <= 1'b0;
         rel        <= 1'b0;
         click      <= 1'b0;
         long_press <= 1'b0;
         rpt        <= 1'b0;
         held       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         press      <= press_d;
         rel        <= rel_d;
         click      <= click_d;
         long_press <= long_d;
         rpt        <= rpt_d;
         held       <= held_d;
      end
   end

   // Release (I=0) is tested first so it wins over a coincident terminal count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      click_d = 1'b0;
      long_d  = 1'b0;
      rpt_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (I) begin
               state_d = ST_PRESS;
               press_d = 1'b1;
            end
         end
         ST_PRESS: begin
            if (!I) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               rel_d   = 1'b1;
               click_d = 1'b1;
            end else if (cnt_q == LONG_T) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         ST_HOLD: begin
            if (!I) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               rel_d   = 1'b1;
            end else if (cnt_q == RPT_T) begin
               cnt_d = '0;
               rpt_d = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      held_d = (state_d == ST_HOLD);
   end

   a_onehot_pulses: assert property (@(posedge clk) disable iff (rst)
      $onehot0({press, rel, long_press, rpt}));
   a_click_with_rel: assert property (@(posedge clk) disable iff (rst)
      click |-> rel);
   a_cnt_press_bound: assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_PRESS) |-> (cnt_q <= LONG_T));
   a_cnt_hold_bound: assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_HOLD) |-> (cnt_q <= RPT_T));

endmodule
